// File: rtl/opcode_type.sv
// Shared encodings for the load/store unit: load selectors, FSM states and
// access-size helpers used by both the controller and the lane aligner.
package opcode_type;

  typedef enum logic [2:0] {
    LD_LB   = 3'b000,
    LD_LH   = 3'b001,
    LD_LW   = 3'b010,
    LD_LBU  = 3'b011,
    LD_LHU  = 3'b100,
    LD_NONE = 3'b111
  } ld_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Stores derive their size from the byte mask, loads from the selector.
  function automatic acc_size_e access_size(input logic wr_en,
                                            input logic [3:0] bmask,
                                            input logic [2:0] ld_sel);
    acc_size_e sz;
    sz = SZ_BYTE;
    if (wr_en) begin
      if (bmask[3] || bmask[2]) sz = SZ_WORD;
      else if (bmask[1])        sz = SZ_HALF;
    end else begin
      if (ld_sel == LD_LW)                          sz = SZ_WORD;
      else if (ld_sel == LD_LH || ld_sel == LD_LHU) sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    if (sz == SZ_HALF)      bad = lane[0];
    else if (sz == SZ_WORD) bad = (lane != 2'b00);
    return bad;
  endfunction

  function automatic logic [3:0] size_mask(input acc_size_e sz);
    logic [3:0] m;
    m = 4'b0001;
    if (sz == SZ_HALF)      m = 4'b0011;
    else if (sz == SZ_WORD) m = 4'b1111;
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: shifts store mask/data onto byte lanes and
// extracts plus extends the addressed lane of a read word.
module lsu_align
  import opcode_type::*;
(
  input  logic [1:0]  st_lane_i,
  input  logic [3:0]  bmask_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_lane_i,
  input  logic [2:0]  ld_sel_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] lane_word;

  assign be_o      = bmask_i << st_lane_i;
  assign wdata_o   = st_data_i << {st_lane_i, 3'b000};
  assign lane_word = rdata_i >> {ld_lane_i, 3'b000};

  always_comb begin
    ld_data_o = 32'd0;
    case (ld_sel_i)
      LD_LB:   ld_data_o = {{24{lane_word[7]}}, lane_word[7:0]};
      LD_LBU:  ld_data_o = {24'd0, lane_word[7:0]};
      LD_LH:   ld_data_o = {{16{lane_word[15]}}, lane_word[15:0]};
      LD_LHU:  ld_data_o = {16'd0, lane_word[15:0]};
      LD_LW:   ld_data_o = lane_word;
      default: ld_data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: single outstanding access, registered
// memory request with timeout abort and one-cycle completion pulse.
module lsu_mem_ctrl
  import opcode_type::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_vld,
  input  logic        wr_en,
  input  logic [3:0]  bmask,
  input  logic [2:0]  ld_sel,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  ld_sel_q, ld_sel_d;
  logic [1:0]  lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;

  acc_size_e   acc_size;
  logic        misaligned;
  logic [3:0]  be_raw;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_ld;

  assign acc_size   = access_size(wr_en, bmask, ld_sel);
  assign misaligned = is_misaligned(acc_size, addr[1:0]);
  // Loads get lane enables sized to the access so memory sees a real mask.
  assign be_raw     = wr_en ? bmask : size_mask(acc_size);

  lsu_align u_align (
    .st_lane_i (addr[1:0]),
    .bmask_i   (be_raw),
    .st_data_i (st_data),
    .be_o      (align_be),
    .wdata_o   (align_wdata),
    .ld_lane_i (lane_q),
    .ld_sel_i  (ld_sel_q),
    .rdata_i   (mem_rdata),
    .ld_data_o (align_ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      ld_sel_q    <= LD_NONE;
      lane_q      <= 2'd0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ld_data_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      ld_sel_q    <= ld_sel_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ld_data_q   <= ld_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    ld_sel_d    = ld_sel_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    ld_data_d   = ld_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (lsu_vld) begin
          ld_data_d = 32'd0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d       = 1'b0;
            mem_we_d    = wr_en;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = align_be;
            mem_wdata_d = align_wdata;
            // Stores carry LD_NONE so the aligner returns zero on completion.
            ld_sel_d    = wr_en ? LD_NONE : ld_sel;
            lane_d      = addr[1:0];
            cnt_d       = '0;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          ld_data_d = align_ld;
          err_d     = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          ld_data_d = 32'd0;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign lsu_done  = (state_q == ST_DONE);
  assign lsu_err   = lsu_done & err_q;
  assign ld_data   = lsu_done ? ld_data_q : 32'd0;
  assign lsu_stall = lsu_vld & (state_q != ST_DONE);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed vector bench for lsu_mem_ctrl with TIMEOUT=4, plus hand-written
// timeout, ack/timeout coincidence and asynchronous reset sequences.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_vld, wr_en, mem_ack;
  logic [3:0]  bmask;
  logic [2:0]  ld_sel;
  logic [31:0] addr, st_data, mem_rdata;
  logic [31:0] ld_data, mem_addr, mem_wdata;
  logic        lsu_stall, lsu_done, lsu_err, mem_req, mem_we;
  logic [3:0]  mem_be;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lsu_vld   (lsu_vld),
    .wr_en     (wr_en),
    .bmask     (bmask),
    .ld_sel    (ld_sel),
    .addr      (addr),
    .st_data   (st_data),
    .ld_data   (ld_data),
    .lsu_stall (lsu_stall),
    .lsu_done  (lsu_done),
    .lsu_err   (lsu_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [3:0]  bm;
    logic [2:0]  ls;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
    logic        e_err;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit got;
    lsu_vld = 1'b1; wr_en = v.wr; bmask = v.bm; ld_sel = v.ls;
    addr = v.a; st_data = v.sd; mem_ack = 1'b0; mem_rdata = 32'd0;
    #1 chk({v.name, ".stall_idle"}, 32'(lsu_stall), 32'd1);
    @(posedge clk); #1; lat = 1;
    if (!v.e_err) begin
      chk({v.name, ".req"},   32'(mem_req), 32'd1);
      chk({v.name, ".addr"},  mem_addr, v.e_addr);
      chk({v.name, ".be"},    32'(mem_be), 32'(v.e_be));
      chk({v.name, ".wdata"}, mem_wdata, v.e_wd);
      chk({v.name, ".we"},    32'(mem_we), 32'(v.wr));
      repeat (v.dly) begin
        @(posedge clk); #1; lat++;
        chk({v.name, ".req_hold"}, 32'(mem_req), 32'd1);
      end
      mem_ack = 1'b1; mem_rdata = v.rd;
      @(posedge clk); #1; lat++;
      mem_ack = 1'b0; mem_rdata = 32'd0;
    end else begin
      chk({v.name, ".no_req"}, 32'(mem_req), 32'd0);
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (lsu_done) got = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    chk({v.name, ".done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({v.name, ".latency"}, 32'(lat), v.e_err ? 32'd1 : 32'(2 + v.dly));
      chk({v.name, ".ld_data"}, ld_data, v.e_ld);
      chk({v.name, ".err"},     32'(lsu_err), 32'(v.e_err));
      chk({v.name, ".stall_done"}, 32'(lsu_stall), 32'd0);
      @(posedge clk); #1;
      lsu_vld = 1'b0;
      chk({v.name, ".done_pulse"}, 32'(lsu_done), 32'd0);
    end
    $display("txn %s addr=0x%08h ld_data=0x%08h err=%0b", v.name, v.a, ld_data, lsu_err);
  endtask

  // Issues lw 0x6000, holds off ack until REQ cycle ack_cyc (0 = never).
  task automatic run_timeout(input string nm, input int ack_cyc, input logic exp_err,
                             input logic [31:0] exp_ld);
    int req_cycles;
    bit got;
    lsu_vld = 1'b1; wr_en = 1'b0; bmask = 4'b0000; ld_sel = 3'b010;
    addr = 32'h0000_6000; st_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    @(posedge clk); #1;
    req_cycles = 0; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (lsu_done) got = 1'b1;
      else begin
        if (mem_req) req_cycles++;
        if (req_cycles == ack_cyc) begin mem_ack = 1'b1; mem_rdata = 32'h5A5A_0001; end
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'd0;
      end
    end
    chk({nm, ".done_seen"},  32'(got), 32'd1);
    chk({nm, ".req_cycles"}, 32'(req_cycles), 32'd4);
    chk({nm, ".err"},        32'(lsu_err), 32'(exp_err));
    chk({nm, ".ld_data"},    ld_data, exp_ld);
    chk({nm, ".req_low"},    32'(mem_req), 32'd0);
    @(posedge clk); #1;
    lsu_vld = 1'b0;
    $display("txn %s req_cycles=%0d err=%0b ld_data=0x%08h", nm, req_cycles, lsu_err, ld_data);
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0; lsu_vld = 1'b0; wr_en = 1'b0; bmask = 4'd0; ld_sel = 3'd0;
    addr = 32'd0; st_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    //         name      wr  bm       ls      addr          st_data       rdata         dly e_addr        e_be     e_wdata       e_ld          e_err
    vt[0]  = '{"sb",     1, 4'b0001, 3'b111, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0, 32'h0000_1000, 4'b1000, 32'hAB00_0000, 32'h0,        0};
    vt[1]  = '{"lb",     0, 4'b0000, 3'b000, 32'h0000_2001, 32'h0,         32'h0000_8000, 0, 32'h0000_2000, 4'b0010, 32'h0,        32'hFFFF_FF80, 0};
    vt[2]  = '{"lbu",    0, 4'b0000, 3'b011, 32'h0000_2001, 32'h0,         32'h0000_8000, 0, 32'h0000_2000, 4'b0010, 32'h0,        32'h0000_0080, 0};
    vt[3]  = '{"lh",     0, 4'b0000, 3'b001, 32'h0000_2002, 32'h0,         32'h8001_1234, 0, 32'h0000_2000, 4'b1100, 32'h0,        32'hFFFF_8001, 0};
    vt[4]  = '{"lhu",    0, 4'b0000, 3'b100, 32'h0000_2002, 32'h0,         32'h8001_1234, 0, 32'h0000_2000, 4'b1100, 32'h0,        32'h0000_8001, 0};
    vt[5]  = '{"lw_mis", 0, 4'b0000, 3'b010, 32'h0000_3002, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,        32'h0,        1};
    vt[6]  = '{"sw",     1, 4'b1111, 3'b111, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0,         0, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0};
    vt[7]  = '{"sh",     1, 4'b0011, 3'b111, 32'h0000_4002, 32'h0000_CAFE, 32'h0,         1, 32'h0000_4000, 4'b1100, 32'hCAFE_0000, 32'h0,        0};
    vt[8]  = '{"lw_dly", 0, 4'b0000, 3'b010, 32'h0000_5004, 32'h0,         32'h1234_5678, 2, 32'h0000_5004, 4'b1111, 32'h0,        32'h1234_5678, 0};
    vt[9]  = '{"sh_mis", 1, 4'b0011, 3'b111, 32'h0000_4001, 32'h0000_1111, 32'h0,         0, 32'h0,         4'b0000, 32'h0,        32'h0,        1};
    vt[10] = '{"lh_mis", 0, 4'b0000, 3'b001, 32'h0000_2003, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,        32'h0,        1};

    #12;
    chk("rst.mem_req",   32'(mem_req), 32'd0);
    chk("rst.mem_we",    32'(mem_we), 32'd0);
    chk("rst.mem_addr",  mem_addr, 32'd0);
    chk("rst.mem_be",    32'(mem_be), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.lsu_done",  32'(lsu_done), 32'd0);
    chk("rst.lsu_err",   32'(lsu_err), 32'd0);
    chk("rst.ld_data",   ld_data, 32'd0);
    $display("txn reset outputs checked");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    run_timeout("timeout", 0, 1'b1, 32'h0);
    run_timeout("ack_at_timeout", 4, 1'b0, 32'h5A5A_0001);

    // Reset asserted during the second REQ cycle while ack is present.
    lsu_vld = 1'b1; wr_en = 1'b0; ld_sel = 3'b010; addr = 32'h0000_7000;
    @(posedge clk); #1;
    chk("rstmid.req1", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    chk("rstmid.req2", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    #1;
    chk("rstmid.req_drop", 32'(mem_req), 32'd0);
    chk("rstmid.addr_clr", mem_addr, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0; lsu_vld = 1'b0;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (lsu_done) done_cnt++;
      @(posedge clk); #1;
    end
    chk("rstmid.no_done", 32'(done_cnt), 32'd0);
    chk("rstmid.idle_req", 32'(mem_req), 32'd0);
    $display("txn reset_mid_access done_pulses=%0d", done_cnt);

    // Controller must still work after the aborted access.
    run_vec(vt[3]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles in REQ waiting for mem_ack before abort.
REQ-002 Ports, listed as name, direction, width, meaning:
- clk in 1: single clock, rising edge.
- rst_n in 1: reset, asynchronous, active-low.
REQ-003 Core-side ports:
- lsu_vld in 1: load/store pending; held stable with operands while lsu_stall=1.
- wr_en in 1: 1 store, 0 load.
- bmask in 4: store byte mask, unshifted (0001 sb, 0011 sh, 1111 sw).
- ld_sel in 3: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu; others mean no load.
- addr in 32: byte address from ALU.
- st_data in 32: rs2 data, low-aligned.
REQ-004 Core-side outputs:
- ld_data out 32: extended load result, valid while lsu_done=1.
- lsu_stall out 1: core holds PC and operands.
- lsu_done out 1: one-cycle completion pulse.
- lsu_err out 1: misalign/timeout flag, valid with lsu_done.
REQ-005 Memory-side ports:
- mem_req out 1: request, held until mem_ack.
- mem_we out 1: write.
- mem_addr out 32: word address, addr with bits [1:0] = 00.
- mem_be out 4: lane byte enables.
- mem_wdata out 32: lane-shifted store data.
- mem_ack in 1: completion; mem_rdata valid same cycle.
- mem_rdata in 32: read word.

Function
REQ-006 FSM states are IDLE, REQ, DONE. Encoding is free.
REQ-007 IDLE, lsu_vld=1, access aligned: register mem_addr, mem_be, mem_wdata, mem_we, ld_sel and addr[1:0], then go to REQ next edge.
REQ-008 IDLE, lsu_vld=1, access misaligned: go to DONE with error set and no memory access. Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-009 REQ: mem_req=1, outputs stable. On mem_ack=1, capture mem_rdata and go to DONE. The timeout counter clears on entry.
REQ-010 REQ with counter reaching TIMEOUT and no mem_ack: drop mem_req, go to DONE with error set. mem_ack in that same cycle takes priority (no error).
REQ-011 DONE: lsu_done=1 for exactly one cycle, then unconditional return to IDLE. A new lsu_vld is accepted the cycle after DONE.
REQ-012 lsu_stall = lsu_vld AND state!=DONE, combinational.
REQ-013 Byte enables and store data:
- mem_be = bmask << addr[1:0].
- mem_wdata = st_data << (8*addr[1:0]).
REQ-014 ld_data = lane (mem_rdata >> 8*addr[1:0]).
- Byte loads: sign-extend bit 7 for lb, zero-extend for lbu.
- Halfword loads: sign-extend bit 15 for lh, zero-extend for lhu.
- lw passes the word unchanged.
- ld_data=0 for stores and errored accesses.
REQ-015 A latency of 2 cycles minimum from lsu_vld acceptance to lsu_done, for mem_ack asserted in the first REQ cycle.
REQ-016 lsu_vld in REQ or DONE is ignored; no queuing.

Reset
REQ-017 rst_n=0 forces IDLE asynchronously, regardless of the current state.
REQ-018 Reset values of outputs and internal registers are all 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, lsu_done, lsu_err, ld_data, timeout counter.
REQ-019 Reset during REQ drops mem_req immediately. No lsu_done is generated for the aborted access.

Structure
REQ-020 The ld_sel encodings (LB, LH, LW, LBU, LHU, NONE=111) and the FSM state enum live in the shared opcode_type package.
REQ-021 Lane shift and load extension reside in one combinational sub-module, lsu_align. The FSM, capture registers and counter stay in lsu_mem_ctrl.

Verification
REQ-022 Store byte:
- Stimulus: sb, addr=0x1003, st_data=0xAB, mem_ack in 1st REQ cycle.
- Response: mem_addr=0x1000, mem_be=1000, mem_wdata=0xAB000000, lsu_done 2 cycles after accept.
REQ-023 Load byte, sign-extended:
- Stimulus: lb, addr=0x2001, mem_rdata=0x0000_8000.
- Response: ld_data=0xFFFFFF80.
- Repeat with lbu: ld_data=0x00000080.
REQ-024 Load halfword:
- Stimulus: lh, addr=0x2002, mem_rdata=0x8001_1234.
- Response: ld_data=0xFFFF8001.
- Repeat with lhu: ld_data=0x00008001.
REQ-025 Misaligned and timeout:
- lw at addr=0x3002: no mem_req, lsu_done with lsu_err=1 one cycle after accept.
- mem_ack never asserted, TIMEOUT=4: lsu_err=1 after 4 REQ cycles.
REQ-026 Async reset mid-access:
- Stimulus: rst_n low in 2nd REQ cycle, with mem_ack arriving the same cycle as the timeout.
- Response: mem_req=0 immediately, no lsu_done; ack/timeout coincidence gives lsu_err=0.
